otter_wb_arbiter: RTL and testbench

//  Write-back controller for the 31x32 register file (x0 hardwired zero).

---
 rtl/otter_wb_arbiter.sv | 107 ++++++++++
 tb/tb_otter_wb_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_wb_arbiter.sv
// otter_wb_arbiter: write-back controller for the 31x32 register file (x0 reads zero).
// Arbitrates the ALU (S0) and load unit (S1) onto the single rfile write port, drives
// that port from registers, and keeps a per-register busy scoreboard for hazard checks.
// Ports:
//   i_clk, i_rst_n                     clock, synchronous active-low reset
//   i_alu_valid/addr/data, o_alu_ready S0 writeback handshake
//   i_ld_valid/addr/data, o_ld_ready   S1 writeback handshake
//   i_rsv_en/addr, o_rsv_ready         destination reservation from decode
//   i_rs1_addr/i_rs2_addr              hazard-check sources
//   o_rs1_busy/o_rs2_busy              registered busy state of rs1/rs2 (comb read)
//   o_w_en/addr/data                   registered rfile write port
module otter_wb_arbiter #(
   parameter int unsigned XLEN  = 32,
   parameter bit          RR_EN = 1'b1
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_alu_valid,
   input  logic [4:0]      i_alu_addr,
   input  logic [XLEN-1:0] i_alu_data,
   output logic            o_alu_ready,
   input  logic            i_ld_valid,
   input  logic [4:0]      i_ld_addr,
   input  logic [XLEN-1:0] i_ld_data,
   output logic            o_ld_ready,
   input  logic            i_rsv_en,
   input  logic [4:0]      i_rsv_addr,
   output logic            o_rsv_ready,
   input  logic [4:0]      i_rs1_addr,
   input  logic [4:0]      i_rs2_addr,
   output logic            o_rs1_busy,
   output logic            o_rs2_busy,
   output logic            o_w_en,
   output logic [4:0]      o_w_addr,
   output logic [XLEN-1:0] o_w_data
);

   localparam int unsigned NREG    = 32;
   localparam int unsigned AW      = 5;
   localparam logic        SRC_ALU = 1'b0;
   localparam logic        SRC_LD  = 1'b1;

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic            last_grant_q;
   logic            grant_ld_c;
   logic            xfer_c;
   logic            rsv_set_c;
   logic [AW-1:0]   sel_addr_c;
   logic [XLEN-1:0] sel_data_c;

   // Source selection: under contention round-robin flips away from the last winner,
   // otherwise the load unit always wins.
   always_comb begin
      grant_ld_c = 1'b0;
      if (i_alu_valid && i_ld_valid) begin
         grant_ld_c = RR_EN ? (last_grant_q == SRC_ALU) : 1'b1;
      end else begin
         grant_ld_c = i_ld_valid;
      end
   end

   assign o_ld_ready  = i_ld_valid && grant_ld_c;
   assign o_alu_ready = i_alu_valid && !grant_ld_c;
   assign xfer_c      = i_alu_valid || i_ld_valid;
   assign sel_addr_c  = grant_ld_c ? i_ld_addr : i_alu_addr;
   assign sel_data_c  = grant_ld_c ? i_ld_data : i_alu_data;

   // Reservation is a WAW stall: a register still busy cannot be re-reserved, even
   // if its clearing write is on the port this very cycle.
   assign o_rsv_ready = (i_rsv_addr == AW'(0)) || !busy_q[i_rsv_addr];
   assign rsv_set_c   = i_rsv_en && o_rsv_ready && (i_rsv_addr != AW'(0));
   assign o_rs1_busy  = busy_q[i_rs1_addr];
   assign o_rs2_busy  = busy_q[i_rs2_addr];

   // Scoreboard next state: clear on the committing write, then apply the new reservation.
   always_comb begin
      busy_d = busy_q;
      if (o_w_en) begin
         busy_d[o_w_addr] = 1'b0;
      end
      if (rsv_set_c) begin
         busy_d[i_rsv_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // State and write-port registers; a transfer to x0 is consumed without a write.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         busy_q       <= '0;
         last_grant_q <= SRC_LD;
         o_w_en       <= 1'b0;
         o_w_addr     <= '0;
         o_w_data     <= '0;
      end else begin
         busy_q <= busy_d;
         o_w_en <= xfer_c && (sel_addr_c != AW'(0));
         if (xfer_c) begin
            last_grant_q <= grant_ld_c;
            o_w_addr     <= sel_addr_c;
            o_w_data     <= sel_data_c;
         end
      end
   end

endmodule

// File: tb/tb_otter_wb_arbiter.sv
// tb_otter_wb_arbiter: self-checking bench for otter_wb_arbiter.
// Instance 0 uses round-robin arbitration, instance 1 fixed priority (load wins).
module tb_otter_wb_arbiter;

   localparam int unsigned XLEN = 32;

   logic            clk;
   logic            rst_n;
   logic            alu_valid [2];
   logic [4:0]      alu_addr  [2];
   logic [XLEN-1:0] alu_data  [2];
   logic            alu_ready [2];
   logic            ld_valid  [2];
   logic [4:0]      ld_addr   [2];
   logic [XLEN-1:0] ld_data   [2];
   logic            ld_ready  [2];
   logic            rsv_en    [2];
   logic [4:0]      rsv_addr  [2];
   logic            rsv_ready [2];
   logic [4:0]      rs1_addr  [2];
   logic [4:0]      rs2_addr  [2];
   logic            rs1_busy  [2];
   logic            rs2_busy  [2];
   logic            w_en      [2];
   logic [4:0]      w_addr    [2];
   logic [XLEN-1:0] w_data    [2];

   otter_wb_arbiter #(.XLEN(XLEN), .RR_EN(1'b1)) dut_rr (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_alu_valid(alu_valid[0]), .i_alu_addr(alu_addr[0]), .i_alu_data(alu_data[0]), .o_alu_ready(alu_ready[0]),
      .i_ld_valid(ld_valid[0]), .i_ld_addr(ld_addr[0]), .i_ld_data(ld_data[0]), .o_ld_ready(ld_ready[0]),
      .i_rsv_en(rsv_en[0]), .i_rsv_addr(rsv_addr[0]), .o_rsv_ready(rsv_ready[0]),
      .i_rs1_addr(rs1_addr[0]), .i_rs2_addr(rs2_addr[0]), .o_rs1_busy(rs1_busy[0]), .o_rs2_busy(rs2_busy[0]),
      .o_w_en(w_en[0]), .o_w_addr(w_addr[0]), .o_w_data(w_data[0])
   );

   otter_wb_arbiter #(.XLEN(XLEN), .RR_EN(1'b0)) dut_fp (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_alu_valid(alu_valid[1]), .i_alu_addr(alu_addr[1]), .i_alu_data(alu_data[1]), .o_alu_ready(alu_ready[1]),
      .i_ld_valid(ld_valid[1]), .i_ld_addr(ld_addr[1]), .i_ld_data(ld_data[1]), .o_ld_ready(ld_ready[1]),
      .i_rsv_en(rsv_en[1]), .i_rsv_addr(rsv_addr[1]), .o_rsv_ready(rsv_ready[1]),
      .i_rs1_addr(rs1_addr[1]), .i_rs2_addr(rs2_addr[1]), .o_rs1_busy(rs1_busy[1]), .o_rs2_busy(rs2_busy[1]),
      .o_w_en(w_en[1]), .o_w_addr(w_addr[1]), .o_w_data(w_data[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: set of reserved registers, last winner, and the pending rfile write.
   bit              m_busy  [2][32];
   bit              m_last  [2];      // 1 = load unit won the last transfer
   bit              m_wen   [2];
   bit [4:0]        m_waddr [2];
   bit [XLEN-1:0]   m_wdata [2];
   bit              ex_ar   [2];
   bit              ex_lr   [2];
   bit              ex_rsv  [2];

   int total;
   int bad;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
      total++;
      assert (obs === req) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   task automatic idle();
      for (int k = 0; k < 2; k++) begin
         alu_valid[k] = 1'b0; alu_addr[k] = '0; alu_data[k] = '0;
         ld_valid[k]  = 1'b0; ld_addr[k]  = '0; ld_data[k]  = '0;
         rsv_en[k]    = 1'b0; rsv_addr[k] = '0;
         rs1_addr[k]  = '0;   rs2_addr[k] = '0;
      end
   endtask

   // One clock: check combinational outputs mid-cycle, advance the model at the edge,
   // then check the registered write port just after the edge.
   task automatic cycle();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         bit rr;
         rr = (k == 0);
         ex_ar[k]  = alu_valid[k] && (!ld_valid[k] || (rr && m_last[k]));
         ex_lr[k]  = ld_valid[k] && !ex_ar[k];
         ex_rsv[k] = (rsv_addr[k] == 5'd0) || !m_busy[k][rsv_addr[k]];
         chk($sformatf("alu_ready%0d", k), alu_ready[k], ex_ar[k]);
         chk($sformatf("ld_ready%0d", k), ld_ready[k], ex_lr[k]);
         chk($sformatf("rsv_ready%0d", k), rsv_ready[k], ex_rsv[k]);
         chk($sformatf("rs1_busy%0d", k), rs1_busy[k], m_busy[k][rs1_addr[k]]);
         chk($sformatf("rs2_busy%0d", k), rs2_busy[k], m_busy[k][rs2_addr[k]]);
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            for (int r = 0; r < 32; r++) m_busy[k][r] = 1'b0;
            m_last[k] = 1'b1; m_wen[k] = 1'b0; m_waddr[k] = '0; m_wdata[k] = '0;
         end else begin
            if (m_wen[k]) m_busy[k][m_waddr[k]] = 1'b0;
            if (rsv_en[k] && ex_rsv[k] && rsv_addr[k] != 5'd0) m_busy[k][rsv_addr[k]] = 1'b1;
            if (ex_ar[k] || ex_lr[k]) begin
               m_last[k]  = ex_lr[k];
               m_waddr[k] = ex_lr[k] ? ld_addr[k] : alu_addr[k];
               m_wdata[k] = ex_lr[k] ? ld_data[k] : alu_data[k];
               m_wen[k]   = (m_waddr[k] != 5'd0);
            end else begin
               m_wen[k] = 1'b0;
            end
         end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("w_en%0d", k), w_en[k], m_wen[k]);
         if (m_wen[k]) begin
            chk($sformatf("w_addr%0d", k), w_addr[k], m_waddr[k]);
            chk($sformatf("w_data%0d", k), w_data[k], m_wdata[k]);
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [XLEN-1:0] exp2 [4];
      int ai;
      int li;
      total = 0;
      bad   = 0;
      for (int k = 0; k < 2; k++) begin
         m_last[k] = 1'b1; m_wen[k] = 1'b0; m_waddr[k] = '0; m_wdata[k] = '0;
         for (int r = 0; r < 32; r++) m_busy[k][r] = 1'b0;
      end
      idle();

      // Reset state
      do_reset();
      do_reset();
      for (int k = 0; k < 2; k++) begin
         chk("rst_w_en", w_en[k], 1'b0);
         chk("rst_w_addr", w_addr[k], 5'd0);
         chk("rst_w_data", w_data[k], 32'd0);
      end

      // Single ALU write
      alu_valid[0] = 1'b1; alu_addr[0] = 5'd5; alu_data[0] = 32'hDEADBEEF;
      #1 chk("t1_ready", alu_ready[0], 1'b1);
      cycle();
      alu_valid[0] = 1'b0;
      chk("t1_w_en", w_en[0], 1'b1);
      chk("t1_w_addr", w_addr[0], 5'd5);
      chk("t1_w_data", w_data[0], 32'hDEADBEEF);

      // Round-robin under constant contention, starting with S0 after reset
      do_reset();
      exp2[0] = 32'hA000_0000; exp2[1] = 32'hB000_0000;
      exp2[2] = 32'hA000_0001; exp2[3] = 32'hB000_0001;
      ai = 0; li = 0;
      alu_valid[0] = 1'b1; alu_addr[0] = 5'd10;
      ld_valid[0]  = 1'b1; ld_addr[0]  = 5'd11;
      for (int i = 0; i < 4; i++) begin
         alu_data[0] = 32'hA000_0000 + XLEN'(ai);
         ld_data[0]  = 32'hB000_0000 + XLEN'(li);
         #1 chk("t2_grant_alu", alu_ready[0], (i % 2) == 0);
         cycle();
         chk("t2_w_data", w_data[0], exp2[i]);
         if ((i % 2) == 0) ai++; else li++;
      end
      alu_valid[0] = 1'b0; ld_valid[0] = 1'b0;

      // Fixed priority: load wins three times, ALU held then written
      alu_valid[1] = 1'b1; alu_addr[1] = 5'd12; alu_data[1] = 32'hC0C0_0000;
      ld_valid[1]  = 1'b1; ld_addr[1]  = 5'd13;
      for (int i = 0; i < 3; i++) begin
         ld_data[1] = 32'hD000_0000 + XLEN'(i);
         #1;
         chk("t3_ld_ready", ld_ready[1], 1'b1);
         chk("t3_alu_ready", alu_ready[1], 1'b0);
         cycle();
         chk("t3_ld_addr", w_addr[1], 5'd13);
         chk("t3_ld_data", w_data[1], 32'hD000_0000 + XLEN'(i));
      end
      ld_valid[1] = 1'b0;
      #1 chk("t3_alu_late_ready", alu_ready[1], 1'b1);
      cycle();
      alu_valid[1] = 1'b0;
      chk("t3_alu_addr", w_addr[1], 5'd12);
      chk("t3_alu_data", w_data[1], 32'hC0C0_0000);

      // Scoreboard: reserve x7, WAW stall, clear two cycles after the load transfer
      rsv_en[0] = 1'b1; rsv_addr[0] = 5'd7;
      #1 chk("t4_rsv_first", rsv_ready[0], 1'b1);
      cycle();
      rs1_addr[0] = 5'd7;
      #1;
      chk("t4_rs1_busy", rs1_busy[0], 1'b1);
      chk("t4_rsv_stall", rsv_ready[0], 1'b0);
      cycle();
      rsv_en[0] = 1'b0;
      ld_valid[0] = 1'b1; ld_addr[0] = 5'd7; ld_data[0] = 32'h77;
      #1 chk("t4_ld_ready", ld_ready[0], 1'b1);
      cycle();
      ld_valid[0] = 1'b0;
      #1;
      chk("t4_busy_during_write", rs1_busy[0], 1'b1);
      chk("t4_w_en", w_en[0], 1'b1);
      cycle();
      #1 chk("t4_busy_cleared", rs1_busy[0], 1'b0);

      // Write to x0 is accepted but never reaches the rfile
      alu_valid[0] = 1'b1; alu_addr[0] = 5'd0; alu_data[0] = 32'h1234;
      #1 chk("t5_ready", alu_ready[0], 1'b1);
      cycle();
      alu_valid[0] = 1'b0;
      chk("t5_w_en", w_en[0], 1'b0);
      rs1_addr[0] = 5'd0;
      #1 chk("t5_x0_busy", rs1_busy[0], 1'b0);

      // Reset at the edge of a transfer drops the write and clears the scoreboard
      for (int k = 0; k < 2; k++) begin rsv_en[k] = 1'b1; rsv_addr[k] = 5'd3; end
      cycle();
      for (int k = 0; k < 2; k++) rsv_addr[k] = 5'd9;
      cycle();
      for (int k = 0; k < 2; k++) begin
         rsv_en[k] = 1'b0;
         alu_valid[k] = 1'b1; alu_addr[k] = 5'd9; alu_data[k] = 32'h99;
      end
      rst_n = 1'b0;
      #1 for (int k = 0; k < 2; k++) chk("t6_ready", alu_ready[k], 1'b1);
      cycle();
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         alu_valid[k] = 1'b0;
         chk("t6_w_en", w_en[k], 1'b0);
      end
      for (int i = 0; i < 32; i++) begin
         for (int k = 0; k < 2; k++) begin
            rs1_addr[k] = 5'(i);
            rs2_addr[k] = 5'(31 - i);
         end
         #1 for (int k = 0; k < 2; k++) chk("t6_busy_clear", rs1_busy[k], 1'b0);
         cycle();
      end

      // Randomized traffic; sources hold addr/data until accepted
      for (int n = 0; n < 600; n++) begin
         for (int k = 0; k < 2; k++) begin
            if (!alu_valid[k] && $urandom_range(0, 2) != 0) begin
               alu_valid[k] = 1'b1;
               alu_addr[k]  = 5'($urandom_range(0, 31));
               alu_data[k]  = $urandom();
            end
            if (!ld_valid[k] && $urandom_range(0, 2) != 0) begin
               ld_valid[k] = 1'b1;
               ld_addr[k]  = 5'($urandom_range(0, 31));
               ld_data[k]  = $urandom();
            end
            rsv_en[k]   = ($urandom_range(0, 2) == 0);
            rsv_addr[k] = 5'($urandom_range(0, 31));
            rs1_addr[k] = 5'($urandom_range(0, 31));
            rs2_addr[k] = 5'($urandom_range(0, 31));
         end
         rst_n = ($urandom_range(0, 99) != 0);
         cycle();
         for (int k = 0; k < 2; k++) begin
            if (ex_ar[k]) alu_valid[k] = 1'b0;
            if (ex_lr[k]) ld_valid[k] = 1'b0;
         end
      end
      rst_n = 1'b1;
      idle();
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
